// File: rtl/pow3_stream_checker.sv
// AXI-Stream sink that checks incoming beats against the sequence 1,3,9,27,... mod 2^DATA_SIZE.
// It keeps saturating beat, packet and error counts and captures the first mismatch.
module pow3_stream_checker #(
  parameter int unsigned DATA_SIZE       = 32,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter bit          STOP_ON_ERR     = 1'b0,
  parameter bit          RESTART_ON_LAST = 1'b0
) (
  input  logic                   s00_axis_aclk,
  input  logic                   s00_axis_areset,
  input  logic                   s00_axis_enable,
  input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
  input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
  input  logic                   s00_axis_tvalid,
  output logic                   s00_axis_tready,
  input  logic                   s00_axis_tlast,
  input  logic                   clear,
  output logic [CNT_WIDTH-1:0]   beat_count,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic                   err_flag,
  output logic [DATA_SIZE-1:0]   err_expected,
  output logic [DATA_SIZE-1:0]   err_received,
  output logic [DATA_SIZE-1:0]   last_data
);

  typedef enum logic [1:0] {StIdle, StRecv, StHalt} state_e;

  state_e               state_q, state_d;
  logic                 tready_q, tready_d;
  logic [DATA_SIZE-1:0] exp_q, exp_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d, pkt_q, pkt_d, err_q, err_d;
  logic                 flag_q, flag_d;
  logic [DATA_SIZE-1:0] eexp_q, eexp_d, erecv_q, erecv_d, last_q, last_d;
  logic                 xfer, mismatch;

  // Byte strobes carry no meaning for this checker.
  logic unused_tstrb;
  assign unused_tstrb = ^s00_axis_tstrb;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign xfer     = s00_axis_tvalid & tready_q;
  assign mismatch = (s00_axis_tdata != exp_q);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    err_d   = err_q;
    flag_d  = flag_q;
    eexp_d  = eexp_q;
    erecv_d = erecv_q;
    last_d  = last_q;

    unique case (state_q)
      StIdle: if (s00_axis_enable) state_d = StRecv;
      StRecv: begin
        if (xfer && mismatch && STOP_ON_ERR) state_d = StHalt;
        else if (!s00_axis_enable)           state_d = StIdle;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase

    if (xfer) begin
      last_d = s00_axis_tdata;
      beat_d = sat_inc(beat_q);
      if (s00_axis_tlast) pkt_d = sat_inc(pkt_q);
      if (mismatch) begin
        err_d  = sat_inc(err_q);
        flag_d = 1'b1;
        if (!flag_q) begin
          eexp_d  = exp_q;
          erecv_d = s00_axis_tdata;
        end
      end
      // Advance from the expected value so a single corrupt beat costs one error.
      if (RESTART_ON_LAST && s00_axis_tlast) exp_d = DATA_SIZE'(1);
      else exp_d = exp_q + {exp_q[DATA_SIZE-2:0], 1'b0};
    end

    // Clear wins over a same-edge transfer.
    if (clear) begin
      state_d = StIdle;
      exp_d   = DATA_SIZE'(1);
      beat_d  = '0;
      pkt_d   = '0;
      err_d   = '0;
      flag_d  = 1'b0;
      eexp_d  = '0;
      erecv_d = '0;
      last_d  = '0;
    end

    tready_d = (state_d == StRecv);
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_q  <= StIdle;
      tready_q <= 1'b0;
      exp_q    <= DATA_SIZE'(1);
      beat_q   <= '0;
      pkt_q    <= '0;
      err_q    <= '0;
      flag_q   <= 1'b0;
      eexp_q   <= '0;
      erecv_q  <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      exp_q    <= exp_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
      flag_q   <= flag_d;
      eexp_q   <= eexp_d;
      erecv_q  <= erecv_d;
      last_q   <= last_d;
    end
  end

  assign s00_axis_tready = tready_q;
  assign beat_count      = beat_q;
  assign pkt_count       = pkt_q;
  assign err_count       = err_q;
  assign err_flag        = flag_q;
  assign err_expected    = eexp_q;
  assign err_received    = erecv_q;
  assign last_data       = last_q;

endmodule

// File: tb/tb_pow3_stream_checker.sv
// Bench for pow3_stream_checker: four instances (default, restart-on-last, stop-on-error,
// 8-bit data with 4-bit counters) checked every cycle against a sequence-index reference model.
module tb_pow3_stream_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0]       en, vld, lst, clr, strb;
  logic [3:0][31:0] dat;
  logic [3:0]       o_rdy, o_flag;
  logic [3:0][31:0] o_beat, o_pkt, o_err, o_eexp, o_erecv, o_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned W  = (g == 3) ? 8 : 32;
    localparam int unsigned C  = (g == 3) ? 4 : 16;
    localparam bit          RL = (g == 1);
    localparam bit          SE = (g == 2);
    logic [C-1:0] bc, pc, ec;
    logic [W-1:0] ee, er, ld;
    logic         rdy, ef;
    pow3_stream_checker #(
      .DATA_SIZE(W), .CNT_WIDTH(C), .STOP_ON_ERR(SE), .RESTART_ON_LAST(RL)
    ) u_dut (
      .s00_axis_aclk  (clk),
      .s00_axis_areset(rst),
      .s00_axis_enable(en[g]),
      .s00_axis_tdata (dat[g][W-1:0]),
      .s00_axis_tstrb (strb[W/8-1:0]),
      .s00_axis_tvalid(vld[g]),
      .s00_axis_tready(rdy),
      .s00_axis_tlast (lst[g]),
      .clear          (clr[g]),
      .beat_count     (bc),
      .pkt_count      (pc),
      .err_count      (ec),
      .err_flag       (ef),
      .err_expected   (ee),
      .err_received   (er),
      .last_data      (ld)
    );
    assign o_rdy[g]   = rdy;
    assign o_flag[g]  = ef;
    assign o_beat[g]  = 32'(bc);
    assign o_pkt[g]   = 32'(pc);
    assign o_err[g]   = 32'(ec);
    assign o_eexp[g]  = 32'(ee);
    assign o_erecv[g] = 32'(er);
    assign o_last[g]  = 32'(ld);
  end

  // Reference model: expected value is 3^k where k counts beats since reset/clear/restart.
  logic [31:0] m_beat[4], m_pkt[4], m_err[4], m_eexp[4], m_erecv[4], m_last[4];
  bit          m_flag[4], m_rdy[4], m_halt[4], m_xfer[4];
  int unsigned m_idx[4];

  function automatic logic [31:0] dmask(int i);
    return (i == 3) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] cmax(int i);
    return (i == 3) ? 32'h0000_000F : 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] pow3(int unsigned k, logic [31:0] mask);
    logic [31:0] v = 32'd1;
    repeat (k) v = (v * 32'd3) & mask;
    return v;
  endfunction

  function automatic logic [31:0] sat(logic [31:0] v, logic [31:0] mx);
    return (v >= mx) ? mx : v + 32'd1;
  endfunction

  task automatic model_reset_one(int i);
    m_beat[i] = 0; m_pkt[i] = 0; m_err[i] = 0; m_eexp[i] = 0; m_erecv[i] = 0; m_last[i] = 0;
    m_flag[i] = 0; m_rdy[i] = 0; m_halt[i] = 0; m_idx[i] = 0;
  endtask

  task automatic model_reset_all();
    for (int i = 0; i < 4; i++) model_reset_one(i);
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) m_xfer[i] = 0;
    if (rst) return;
    for (int i = 0; i < 4; i++) begin
      bit          x, mis;
      logic [31:0] e, d;
      if (clr[i]) begin
        model_reset_one(i);
        continue;
      end
      x   = vld[i] && m_rdy[i];
      mis = 0;
      m_xfer[i] = x;
      if (x) begin
        e   = pow3(m_idx[i], dmask(i));
        d   = dat[i] & dmask(i);
        mis = (d != e);
        m_beat[i] = sat(m_beat[i], cmax(i));
        if (lst[i]) m_pkt[i] = sat(m_pkt[i], cmax(i));
        if (mis) begin
          m_err[i] = sat(m_err[i], cmax(i));
          if (!m_flag[i]) begin
            m_eexp[i]  = e;
            m_erecv[i] = d;
          end
          m_flag[i] = 1;
        end
        m_last[i] = d;
        m_idx[i]  = (i == 1 && lst[i]) ? 0 : m_idx[i] + 1;
      end
      if (!m_halt[i]) begin
        if (m_rdy[i] && x && mis && i == 2) begin
          m_rdy[i]  = 0;
          m_halt[i] = 1;
        end else begin
          m_rdy[i] = en[i];
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, want);
    end
  endtask

  task automatic check_one(int i);
    chk($sformatf("d%0d_tready", i), 32'(o_rdy[i]), 32'(m_rdy[i]));
    chk($sformatf("d%0d_beat", i), o_beat[i], m_beat[i]);
    chk($sformatf("d%0d_pkt", i), o_pkt[i], m_pkt[i]);
    chk($sformatf("d%0d_err", i), o_err[i], m_err[i]);
    chk($sformatf("d%0d_flag", i), 32'(o_flag[i]), 32'(m_flag[i]));
    chk($sformatf("d%0d_eexp", i), o_eexp[i], m_eexp[i]);
    chk($sformatf("d%0d_erecv", i), o_erecv[i], m_erecv[i]);
    chk($sformatf("d%0d_last", i), o_last[i], m_last[i]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) check_one(i);
  endtask

  task automatic send(logic [3:0] mask, logic [31:0] data, logic last);
    int first = 0;
    bit ok = 0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) begin
        vld[i] = 1'b1;
        dat[i] = data;
        lst[i] = last;
        first  = i;
      end
    end
    for (int t = 0; t < 16; t++) begin
      cycle();
      if (m_xfer[first]) begin
        ok = 1;
        break;
      end
    end
    chk("send_handshake", 32'(ok), 32'd1);
  endtask

  task automatic idle(logic [3:0] mask);
    vld &= ~mask;
    lst &= ~mask;
  endtask

  task automatic clear_pulse(logic [3:0] mask);
    clr |= mask;
    cycle();
    clr &= ~mask;
  endtask

  initial begin
    en = '0; vld = '0; lst = '0; clr = '0; strb = '0; dat = '0;
    model_reset_all();
    #1 rst = 1'b1;
    #1;
    chk("rst_tready", 32'(o_rdy[0]), 32'd0);
    chk("rst_beat", o_beat[0], 32'd0);
    repeat (2) cycle();
    #2 rst = 1'b0;

    // Test 1: clean sequence
    en[0] = 1'b1;
    cycle();
    chk("t1_tready_after_enable", 32'(o_rdy[0]), 32'd1);
    send(4'b0001, 32'd1, 1'b0);
    send(4'b0001, 32'd3, 1'b0);
    send(4'b0001, 32'd9, 1'b0);
    send(4'b0001, 32'd27, 1'b0);
    send(4'b0001, 32'd81, 1'b0);
    idle(4'b0001);
    chk("t1_beat", o_beat[0], 32'd5);
    chk("t1_err", o_err[0], 32'd0);
    chk("t1_flag", 32'(o_flag[0]), 32'd0);
    chk("t1_last", o_last[0], 32'd81);

    // Test 2: single corrupt beat
    clear_pulse(4'b0001);
    send(4'b0001, 32'd1, 1'b0);
    send(4'b0001, 32'd3, 1'b0);
    send(4'b0001, 32'd10, 1'b0);
    send(4'b0001, 32'd27, 1'b0);
    idle(4'b0001);
    chk("t2_flag", 32'(o_flag[0]), 32'd1);
    chk("t2_err", o_err[0], 32'd1);
    chk("t2_eexp", o_eexp[0], 32'd9);
    chk("t2_erecv", o_erecv[0], 32'd10);
    chk("t2_beat", o_beat[0], 32'd4);

    // Test 3: enable dropped mid-stream while 27 waits
    clear_pulse(4'b0001);
    send(4'b0001, 32'd1, 1'b0);
    send(4'b0001, 32'd3, 1'b0);
    send(4'b0001, 32'd9, 1'b0);
    idle(4'b0001);
    en[0] = 1'b0;
    cycle();
    chk("t3_tready_falls", 32'(o_rdy[0]), 32'd0);
    vld[0] = 1'b1;
    dat[0] = 32'd27;
    repeat (2) cycle();
    chk("t3_beat_held", o_beat[0], 32'd3);
    en[0] = 1'b1;
    send(4'b0001, 32'd27, 1'b0);
    idle(4'b0001);
    chk("t3_beat", o_beat[0], 32'd4);
    chk("t3_err", o_err[0], 32'd0);

    // Test 4: tlast restart vs no restart on the same stream
    en[1] = 1'b1;
    clear_pulse(4'b0011);
    send(4'b0011, 32'd1, 1'b0);
    send(4'b0011, 32'd3, 1'b0);
    send(4'b0011, 32'd9, 1'b0);
    send(4'b0011, 32'd27, 1'b1);
    send(4'b0011, 32'd1, 1'b0);
    idle(4'b0011);
    chk("t4_restart_pkt", o_pkt[1], 32'd1);
    chk("t4_restart_err", o_err[1], 32'd0);
    chk("t4_norestart_pkt", o_pkt[0], 32'd1);
    chk("t4_norestart_err", o_err[0], 32'd1);

    // Test 5: stop on first error, then clear
    en[2] = 1'b1;
    send(4'b0100, 32'd1, 1'b0);
    send(4'b0100, 32'd5, 1'b0);
    chk("t5_halt_tready", 32'(o_rdy[2]), 32'd0);
    repeat (3) cycle();
    chk("t5_halt_held", 32'(o_rdy[2]), 32'd0);
    chk("t5_halt_beat", o_beat[2], 32'd2);
    idle(4'b0100);
    clear_pulse(4'b0100);
    chk("t5_clr_tready", 32'(o_rdy[2]), 32'd0);
    chk("t5_clr_beat", o_beat[2], 32'd0);
    chk("t5_clr_err", o_err[2], 32'd0);
    chk("t5_clr_flag", 32'(o_flag[2]), 32'd0);

    // Test 6: 8-bit wrap, counter saturation, async reset between edges
    en[3] = 1'b1;
    send(4'b1000, 32'd1, 1'b0);
    send(4'b1000, 32'd3, 1'b0);
    send(4'b1000, 32'd9, 1'b0);
    send(4'b1000, 32'd27, 1'b0);
    send(4'b1000, 32'd81, 1'b0);
    send(4'b1000, 32'd243, 1'b0);
    send(4'b1000, 32'd217, 1'b0);
    chk("t6_wrap_err", o_err[3], 32'd0);
    chk("t6_wrap_last", o_last[3], 32'd217);
    for (int k = 0; k < 12; k++) send(4'b1000, pow3(m_idx[3], dmask(3)), 1'b0);
    idle(4'b1000);
    chk("t6_beat_sat", o_beat[3], 32'd15);
    #3 rst = 1'b1;
    #1;
    model_reset_all();
    for (int i = 0; i < 4; i++) check_one(i);
    chk("t6_async_tready", 32'(o_rdy[3]), 32'd0);
    chk("t6_async_beat", o_beat[3], 32'd0);
    repeat (2) cycle();
    #2 rst = 1'b0;

    // Randomised traffic on all instances
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        en[i]  = ($urandom % 8) != 0;
        vld[i] = ($urandom % 4) != 0;
        lst[i] = ($urandom % 6) == 0;
        clr[i] = ($urandom % 50) == 0;
        dat[i] = (($urandom % 8) == 0) ? $urandom : pow3(m_idx[i], dmask(i));
      end
      strb = 4'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
